// File: rtl/m_divide_8x4_pkg.sv
// Shared definitions for the iterative 8/4 unsigned divider.
//   DIV_DIVIDEND_WIDTH : dividend / quotient width (N)
//   DIV_DIVISOR_WIDTH  : divisor / remainder width (M)
//   DIV_CNT_WIDTH      : bit-counter width, wide enough to hold N
//   div_state_e        : IDLE / CALC / DONE control states
package m_divide_8x4_pkg;

  localparam int DIV_DIVIDEND_WIDTH = 8;
  localparam int DIV_DIVISOR_WIDTH  = 4;
  localparam int DIV_CNT_WIDTH      = $clog2(DIV_DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/m_div_step.sv
// One restoring-division step, purely combinational.
//   partial_rem  [M:0] : running partial remainder
//   dividend_msb       : next dividend bit shifted into the remainder
//   divisor      [M-1:0]
//   next_rem     [M:0] : partial remainder after this step
//   q_bit              : quotient bit produced by this step
// Kept separate so the iterative divider can later be unrolled into a pipeline.
module m_div_step #(
  parameter int M = 4
) (
  input  logic [M:0]   partial_rem,
  input  logic         dividend_msb,
  input  logic [M-1:0] divisor,
  output logic [M:0]   next_rem,
  output logic         q_bit
);

  // The remainder never reaches the divisor, so partial_rem[M] is always 0
  // and the full-width trial compares identically to {partial_rem[M-1:0], msb}.
  logic [M+1:0] trial;

  assign trial    = {partial_rem, dividend_msb};
  assign q_bit    = (trial >= {2'b00, divisor});
  assign next_rem = q_bit ? (trial[M:0] - {1'b0, divisor}) : trial[M:0];

endmodule

// File: rtl/m_divide_8x4.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   start_i             : request, accepted when ready_o
//   dividend_i/divisor_i: operands, sampled on the accepted start
//   ready_o             : a start can be accepted (IDLE or DONE)
//   busy_o              : iterating (CALC)
//   valid_o             : one-cycle pulse, fresh result on the outputs
//   quotient_o/remainder_o/div_zero_o : registered result of the last op
module m_divide_8x4
  import m_divide_8x4_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DIV_DIVISOR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic                      valid_o,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  remainder_o,
  output logic                      div_zero_o
);

  localparam int N  = DIVIDEND_WIDTH;
  localparam int M  = DIVISOR_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  work_q;     // dividend bits shift out the top, quotient bits in the bottom
  logic [M-1:0]  divisor_q;
  logic [M-1:0]  dvd_lo_q;   // low dividend bits, the forced remainder for divide-by-zero
  logic [M:0]    rem_q;
  logic [M:0]    step_rem;
  logic          step_q;
  logic          accept;
  logic          calc_last;

  m_div_step #(.M(M)) u_step (
    .partial_rem  (rem_q),
    .dividend_msb (work_q[N-1]),
    .divisor      (divisor_q),
    .next_rem     (step_rem),
    .q_bit        (step_q)
  );

  assign ready_o   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_o    = (state_q == ST_CALC);
  assign valid_o   = (state_q == ST_DONE);
  assign accept    = start_i && ready_o;
  assign calc_last = (state_q == ST_CALC) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CALC;
      ST_CALC: if (calc_last) state_d = ST_DONE;
      ST_DONE: state_d = start_i ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      dvd_lo_q    <= '0;
      rem_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        work_q    <= dividend_i;
        divisor_q <= divisor_i;
        dvd_lo_q  <= dividend_i[M-1:0];
        rem_q     <= '0;
        cnt_q     <= '0;
      end else if (state_q == ST_CALC) begin
        work_q <= {work_q[N-2:0], step_q};
        rem_q  <= step_rem;
        cnt_q  <= cnt_q + 1'b1;
      end
      // Result registers only move on CALC->DONE, taking the final step directly.
      if (calc_last) begin
        if (divisor_q == '0) begin
          quotient_o  <= '1;
          remainder_o <= dvd_lo_q;
          div_zero_o  <= 1'b1;
        end else begin
          quotient_o  <= {work_q[N-2:0], step_q};
          remainder_o <= step_rem[M-1:0];
          div_zero_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_m_divide_8x4.sv
module tb_m_divide_8x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic       ready_o, busy_o, valid_o, div_zero_o;
  logic [7:0] quotient_o;
  logic [3:0] remainder_o;

  m_divide_8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = a[3:0]; e.dz = 1'b1;
    end else begin
      e.q = a / {4'd0, b}; e.r = 4'(a % {4'd0, b}); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start for one cycle (the accept cycle, "cycle 0") and records the
  // expected result; returns in cycle 1.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    sb.push_back(model(a, b));
    tick();
    start_i    = 1'b0;
    dividend_i = 8'($urandom);
    divisor_i  = 4'($urandom);
  endtask

  task automatic wait_valid(input int c0, output int cyc, output bit ok);
    cyc = c0;
    while (valid_o !== 1'b1 && cyc < c0 + 16) begin
      tick();
      cyc++;
    end
    ok = (valid_o === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (quotient_o !== 8'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", quotient_o); end
    total++; if (remainder_o !== 4'd0) begin bad++; $display("FAIL reset_r got=%0d exp=0", remainder_o); end
    total++; if (div_zero_o !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero_o); end
  endtask

  task automatic test_latency();
    exp_t e;
    launch(8'd200, 4'd7);
    for (int c = 1; c <= 8; c++) begin
      total++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
        bad++; $display("FAIL lat_busy cycle=%0d busy=%b valid=%b exp busy=1 valid=0", c, busy_o, valid_o);
      end
      tick();
    end
    e = sb.pop_front();
    total++; if (valid_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL lat_valid cycle=9 valid=%b busy=%b exp valid=1 busy=0", valid_o, busy_o);
    end
    total++; if ({quotient_o, remainder_o, div_zero_o} !== {e.q, e.r, e.dz}) begin
      bad++; $display("FAIL lat_result got=%0d r%0d dz%b exp=%0d r%0d dz%b",
                      quotient_o, remainder_o, div_zero_o, e.q, e.r, e.dz);
    end
    tick();
    total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL lat_pulse valid=%b ready=%b exp valid=0 ready=1", valid_o, ready_o);
    end
  endtask

  task automatic test_values();
    logic [7:0] ta [6] = '{8'd255, 8'd0, 8'd5, 8'd255, 8'd100, 8'd100};
    logic [3:0] tb [6] = '{4'd15,  4'd3, 4'd9, 4'd1,   4'd0,   4'd10};
    int cyc; bit ok; exp_t e;
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], tb[i]);
      wait_valid(1, cyc, ok);
      e = sb.pop_front();
      total++; if (!ok || cyc != 9) begin
        bad++; $display("FAIL val_latency %0d/%0d got=%0d exp=9", ta[i], tb[i], cyc);
      end
      total++; if ({quotient_o, remainder_o, div_zero_o} !== {e.q, e.r, e.dz}) begin
        bad++; $display("FAIL val_result %0d/%0d got=%0d r%0d dz%b exp=%0d r%0d dz%b", ta[i], tb[i],
                        quotient_o, remainder_o, div_zero_o, e.q, e.r, e.dz);
      end
      tick();
    end
  endtask

  task automatic test_ignore_back_to_back();
    int cyc; bit ok; exp_t e;
    launch(8'd17, 4'd3);                       // cycle 0 -> now cycle 1
    tick(); tick();                            // cycle 3
    start_i = 1'b1; dividend_i = 8'd99; divisor_i = 4'd2;
    tick(); start_i = 1'b0;                    // cycle 4
    tick();                                    // cycle 5
    start_i = 1'b1; dividend_i = 8'd99; divisor_i = 4'd2;
    tick(); start_i = 1'b0;                    // cycle 6
    wait_valid(6, cyc, ok);
    e = sb.pop_front();
    total++; if (!ok || cyc != 9) begin bad++; $display("FAIL ign_latency got=%0d exp=9", cyc); end
    total++; if ({quotient_o, remainder_o} !== {e.q, e.r}) begin
      bad++; $display("FAIL ign_result got=%0d r%0d exp=%0d r%0d", quotient_o, remainder_o, e.q, e.r);
    end
    launch(8'd99, 4'd2);                       // start in the DONE cycle (9) -> cycle 10
    wait_valid(10, cyc, ok);
    e = sb.pop_front();
    total++; if (!ok || cyc != 18) begin bad++; $display("FAIL b2b_latency got=%0d exp=18", cyc); end
    total++; if ({quotient_o, remainder_o} !== {e.q, e.r}) begin
      bad++; $display("FAIL b2b_result got=%0d r%0d exp=%0d r%0d", quotient_o, remainder_o, e.q, e.r);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int vcnt; exp_t e;
    launch(8'd123, 4'd5);
    tick(); tick(); tick();                    // cycle 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());                     // aborted, never completes
    total++; if ({ready_o, busy_o, valid_o} !== 3'b100) begin
      bad++; $display("FAIL rstmid_ctrl got=%b exp=100", {ready_o, busy_o, valid_o});
    end
    total++; if ({quotient_o, remainder_o, div_zero_o} !== 13'd0) begin
      bad++; $display("FAIL rstmid_out got=%0d r%0d dz%b exp=0 r0 dz0", quotient_o, remainder_o, div_zero_o);
    end
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid_o === 1'b1) vcnt++;
      tick();
    end
    total++; if (vcnt != 0) begin bad++; $display("FAIL rstmid_novalid got=%0d exp=0", vcnt); end
    launch(8'd60, 4'd4);
    wait_valid(1, cyc, ok);
    e = sb.pop_front();
    total++; if (!ok || cyc != 9) begin bad++; $display("FAIL rstmid_latency got=%0d exp=9", cyc); end
    total++; if ({quotient_o, remainder_o, div_zero_o} !== {e.q, e.r, e.dz}) begin
      bad++; $display("FAIL rstmid_result got=%0d r%0d exp=%0d r%0d", quotient_o, remainder_o, e.q, e.r);
    end
    tick();
  endtask

  task automatic test_hold();
    int cyc; bit ok; exp_t e;
    launch(8'd200, 4'd7);
    wait_valid(1, cyc, ok);
    e = sb.pop_front();
    total++; if (!ok || {quotient_o, remainder_o} !== {e.q, e.r}) begin
      bad++; $display("FAIL hold_first got=%0d r%0d exp=%0d r%0d", quotient_o, remainder_o, e.q, e.r);
    end
    launch(8'd100, 4'd0);
    for (int c = 1; c <= 8; c++) begin
      total++; if ({quotient_o, remainder_o, div_zero_o} !== {8'd28, 4'd4, 1'b0}) begin
        bad++; $display("FAIL hold_stable cycle=%0d got=%0d r%0d dz%b exp=28 r4 dz0",
                        c, quotient_o, remainder_o, div_zero_o);
      end
      tick();
    end
    e = sb.pop_front();
    total++; if (valid_o !== 1'b1 || {quotient_o, remainder_o, div_zero_o} !== {e.q, e.r, e.dz}) begin
      bad++; $display("FAIL hold_next valid=%b got=%0d r%0d dz%b exp=%0d r%0d dz%b",
                      valid_o, quotient_o, remainder_o, div_zero_o, e.q, e.r, e.dz);
    end
    tick();
  endtask

  task automatic test_sweep();
    int cyc; bit ok; exp_t e; int sum;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_valid(1, cyc, ok);
        e = sb.pop_front();
        total++; if (!ok) begin
          bad++; $display("FAIL sweep_timeout %0d/%0d", a, b);
          return;
        end
        total++; if ({quotient_o, remainder_o, div_zero_o} !== {e.q, e.r, e.dz}) begin
          bad++; $display("FAIL sweep %0d/%0d got=%0d r%0d dz%b exp=%0d r%0d dz%b", a, b,
                          quotient_o, remainder_o, div_zero_o, e.q, e.r, e.dz);
        end
        if (b != 0) begin
          sum = int'(quotient_o) * b + int'(remainder_o);
          total++; if (sum != a || int'(remainder_o) >= b) begin
            bad++; $display("FAIL sweep_invariant %0d/%0d q*d+r=%0d r=%0d exp=%0d r<%0d",
                            a, b, sum, remainder_o, a, b);
          end
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_ignore_back_to_back();
    test_reset_mid();
    test_hold();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
